// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: ALU ops, opcodes, functs,
// FSM states, instruction classes and datapath mux selects.
package mc_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SRL = 3'b100,
        ALU_SRA = 3'b101
    } alu_op_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        C_RTYPE = 4'd0,
        C_ORI   = 4'd1,
        C_LUI   = 4'd2,
        C_LW    = 4'd3,
        C_SW    = 4'd4,
        C_BEQ   = 4'd5,
        C_J     = 4'd6,
        C_JAL   = 4'd7,
        C_JR    = 4'd8,
        C_ILL   = 4'd9
    } iclass_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_ZEXT = 2'b01;
    localparam logic [1:0] SRCB_SEXT = 2'b10;
    localparam logic [1:0] SRCB_LUI  = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_JMP = 2'b10;
    localparam logic [1:0] NPC_RS  = 2'b11;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier. jal/jr are recognised only when
// MC_CTRL_JAL_JR_EN is defined; otherwise they fall through to illegal.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] iclass,
    output logic [2:0] alu_op,
    output logic       illegal
);

    iclass_e cls;
    alu_op_e op;

    always_comb begin
        cls = C_ILL;
        op  = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                cls = C_RTYPE;
                case (funct)
                    FN_ADDU: op = ALU_ADD;
                    FN_SUBU: op = ALU_SUB;
                    FN_AND:  op = ALU_AND;
                    FN_OR:   op = ALU_OR;
                    FN_SRLV: op = ALU_SRL;
                    FN_SRAV: op = ALU_SRA;
`ifdef MC_CTRL_JAL_JR_EN
                    FN_JR:   cls = C_JR;
`endif
                    default: cls = C_ILL;
                endcase
            end
            OP_ORI: begin cls = C_ORI; op = ALU_OR;  end
            OP_LUI: begin cls = C_LUI; op = ALU_ADD; end
            OP_LW:  begin cls = C_LW;  op = ALU_ADD; end
            OP_SW:  begin cls = C_SW;  op = ALU_ADD; end
            OP_BEQ: begin cls = C_BEQ; op = ALU_SUB; end
            OP_J:   cls = C_J;
`ifdef MC_CTRL_JAL_JR_EN
            OP_JAL: cls = C_JAL;
`endif
            default: cls = C_ILL;
        endcase
    end

    assign iclass  = cls;
    assign alu_op  = op;
    assign illegal = (cls == C_ILL);

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control FSM (FETCH/DECODE/EXE/MEM/WB).
// Optional jal/jr support is enabled with MC_CTRL_JAL_JR_EN.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic       mem_we,
    output logic [2:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic [1:0] npc_sel,
    output logic       illegal
);

    state_e     state_q, state_d;
    logic [3:0] dec_class;
    logic [2:0] dec_alu_op;
    logic       dec_illegal;
    iclass_e    cls;

    mc_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .iclass  (dec_class),
        .alu_op  (dec_alu_op),
        .illegal (dec_illegal)
    );

    assign cls = iclass_e'(dec_class);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (cls)
                    C_J, C_JR, C_ILL: state_d = S_FETCH;
                    C_JAL:            state_d = S_WB;
                    default:          state_d = S_EXE;
                endcase
            end
            S_EXE: begin
                case (cls)
                    C_BEQ:      state_d = S_FETCH;
                    C_LW, C_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM:   state_d = (cls == C_LW) ? S_WB : S_FETCH;
            S_WB:    state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        mem_we    = 1'b0;
        alu_op    = ALU_ADD;
        alu_src_b = SRCB_RT;
        reg_dst   = DST_RT;
        wd_sel    = WD_ALU;
        npc_sel   = NPC_PC4;
        illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_we = 1'b1;
                pc_we = 1'b1;
            end
            S_DECODE: begin
                illegal = dec_illegal;
                if (cls == C_J) begin
                    pc_we   = 1'b1;
                    npc_sel = NPC_JMP;
                end else if (cls == C_JR) begin
                    pc_we   = 1'b1;
                    npc_sel = NPC_RS;
                end
            end
            S_EXE: begin
                alu_op = dec_alu_op;
                case (cls)
                    C_ORI:      alu_src_b = SRCB_ZEXT;
                    C_LUI:      alu_src_b = SRCB_LUI;
                    C_LW, C_SW: alu_src_b = SRCB_SEXT;
                    default:    alu_src_b = SRCB_RT;
                endcase
                if (cls == C_BEQ) begin
                    pc_we   = zero;
                    npc_sel = NPC_BR;
                end
            end
            S_MEM: mem_we = (cls == C_SW);
            S_WB: begin
                reg_we = 1'b1;
                case (cls)
                    C_RTYPE: reg_dst = DST_RD;
                    C_LW:    wd_sel  = WD_MEM;
                    C_JAL: begin
                        reg_dst = DST_RA;
                        wd_sel  = WD_PC4;
                        pc_we   = 1'b1;
                        npc_sel = NPC_JMP;
                    end
                    default: reg_dst = DST_RT;
                endcase
            end
            default: ;
        endcase
        // Reset masks everything so an aborted instruction never writes.
        if (reset) begin
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            reg_we    = 1'b0;
            mem_we    = 1'b0;
            alu_op    = ALU_ADD;
            alu_src_b = SRCB_RT;
            reg_dst   = DST_RT;
            wd_sel    = WD_ALU;
            npc_sel   = NPC_PC4;
            illegal   = 1'b0;
        end
    end

endmodule
